// File: rtl/knn_point_streamer_if.sv
// Bundle of the query/training handshakes and the emitted word stream
// between the kNN point source, knn_point_streamer and the distance datapath.
//
// Handshake rule used by every channel in this bundle: a word moves on a
// rising clk edge exactly when its valid and ready are both high in the cycle
// before that edge. A source holds its data and valid stable until that edge.
// Ready never depends combinationally on valid. outValid has no ready: the
// downstream accumulator always takes a word when outValid is high.
interface knn_point_streamer_if #(
    parameter int dataWidth = 32
);
    logic                 start;
    logic [31:0]          numPoints;
    logic [dataWidth-1:0] refIn;
    logic                 refValid;
    logic                 refReady;
    logic [31:0]          ptNameIn;
    logic [dataWidth-1:0] ptValueIn;
    logic                 ptValid;
    logic                 ptReady;
    logic                 outValid;
    logic                 loadRef;
    logic [dataWidth-1:0] refDataOut;
    logic [31:0]          dataNameOut;
    logic [dataWidth-1:0] dataValueOut;
    logic                 done;
    logic                 busy;

    // Source / downstream side (drives start and both input streams).
    modport master (
        output start, numPoints, refIn, refValid, ptNameIn, ptValueIn, ptValid,
        input  refReady, ptReady, outValid, loadRef, refDataOut, dataNameOut,
               dataValueOut, done, busy
    );

    // Streamer side.
    modport slave (
        input  start, numPoints, refIn, refValid, ptNameIn, ptValueIn, ptValid,
        output refReady, ptReady, outValid, loadRef, refDataOut, dataNameOut,
               dataValueOut, done, busy
    );
endinterface

// File: rtl/knn_point_streamer.sv
// knn_point_streamer: takes one query point and then numPoints training points
// from bursty sources, buffers each training point completely in one of two
// ping-pong banks and replays it as numberOfDimensions back-to-back words, so
// the per-dimension accumulator downstream never sees a bubble inside a point.
// The first emitted point carries loadRef with the matching query word.
// State encoding is visible on dbg_state_o (0 IDLE, 1 REF_FILL, 2 RUN, 3 FINISH).
// FINISH is the cycle in which the final word of the query is on the outputs;
// done pulses in the following cycle, when the block is back in IDLE.
module knn_point_streamer #(
    parameter int dataWidth          = 32,
    parameter int numberOfDimensions = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    knn_point_streamer_if.slave  bus,
    output logic [1:0]           dbg_state_o
);
    localparam int D  = numberOfDimensions;
    localparam int IW = $clog2(D);
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    typedef enum logic [1:0] {IDLE, REF_FILL, RUN, FINISH} state_t;

    state_t               state_q, state_d;
    logic [31:0]          num_points_q, num_points_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [IW-1:0]        ref_idx_q, ref_idx_d;
    logic                 fill_ptr_q, fill_ptr_d;
    logic [IW-1:0]        fill_idx_q, fill_idx_d;
    logic [1:0]           full_q, full_d;
    logic [31:0]          accepted_q, accepted_d;
    logic                 drain_ptr_q, drain_ptr_d;
    logic [31:0]          emitted_q, emitted_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_bank_q, out_bank_d;
    logic [IW-1:0]        out_idx_q, out_idx_d;
    logic                 load_ref_q, load_ref_d;
    logic [dataWidth-1:0] ref_data_q, ref_data_d;
    logic [31:0]          name_q, name_d;
    logic [dataWidth-1:0] value_q, value_d;

    logic [dataWidth-1:0] ref_buf   [D];
    logic [dataWidth-1:0] bank_val  [2][D];
    logic [31:0]          bank_name [2];

    logic                 ref_ready, ref_fire;
    logic                 pt_ready, pt_fire, fill_done, drain_done;
    logic [1:0]           avail;
    logic                 next_bank;
    logic                 emit_go, emit_bank;
    logic [IW-1:0]        emit_idx;

    // Next-state logic: query sequencing, bank bookkeeping and word emission.
    always_comb begin
        state_d      = state_q;
        num_points_d = num_points_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ref_idx_d    = ref_idx_q;
        fill_ptr_d   = fill_ptr_q;
        fill_idx_d   = fill_idx_q;
        full_d       = full_q;
        accepted_d   = accepted_q;
        drain_ptr_d  = drain_ptr_q;
        emitted_d    = emitted_q;
        out_valid_d  = 1'b0;
        out_bank_d   = out_bank_q;
        out_idx_d    = '0;
        load_ref_d   = 1'b0;
        ref_data_d   = '0;
        name_d       = '0;
        value_d      = '0;
        emit_go      = 1'b0;
        emit_bank    = drain_ptr_q;
        emit_idx     = '0;

        ref_ready  = (state_q == REF_FILL);
        ref_fire   = ref_ready && bus.refValid;
        pt_ready   = (state_q == RUN) && !full_q[fill_ptr_q] && (accepted_q < num_points_q);
        pt_fire    = pt_ready && bus.ptValid;
        fill_done  = pt_fire && (fill_idx_q == LAST);
        drain_done = out_valid_q && (out_idx_q == LAST);

        // A bank completing its fill this cycle may start draining at this
        // edge; its word 0 was written several cycles earlier.
        avail = full_q;
        if (fill_done) begin
            avail[fill_ptr_q] = 1'b1;
        end
        next_bank = drain_done ? ~drain_ptr_q : drain_ptr_q;

        // Fill and drain always touch different banks, so both may land in
        // the same cycle without losing a point.
        if (pt_fire) begin
            if (fill_done) begin
                fill_idx_d         = '0;
                fill_ptr_d         = ~fill_ptr_q;
                full_d[fill_ptr_q] = 1'b1;
                accepted_d         = accepted_q + 32'd1;
            end else begin
                fill_idx_d = fill_idx_q + 1'b1;
            end
        end
        if (drain_done) begin
            full_d[out_bank_q] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    num_points_d = bus.numPoints;
                    busy_d       = 1'b1;
                    ref_idx_d    = '0;
                    accepted_d   = '0;
                    emitted_d    = '0;
                    state_d      = (bus.numPoints == 32'd0) ? FINISH : REF_FILL;
                end
            end
            REF_FILL: begin
                if (ref_fire) begin
                    if (ref_idx_q == LAST) begin
                        ref_idx_d = '0;
                        state_d   = RUN;
                    end else begin
                        ref_idx_d = ref_idx_q + 1'b1;
                    end
                end
            end
            RUN: begin
                // Continue the current point, otherwise start the next bank
                // in fill order as soon as it is available.
                if (out_valid_q && !drain_done) begin
                    emit_go   = 1'b1;
                    emit_bank = out_bank_q;
                    emit_idx  = out_idx_q + 1'b1;
                end else if (avail[next_bank]) begin
                    emit_go   = 1'b1;
                    emit_bank = next_bank;
                    emit_idx  = '0;
                end
                drain_ptr_d = next_bank;
                if (emit_go) begin
                    out_valid_d = 1'b1;
                    out_bank_d  = emit_bank;
                    out_idx_d   = emit_idx;
                    value_d     = bank_val[emit_bank][emit_idx];
                    name_d      = bank_name[emit_bank];
                    load_ref_d  = (emitted_q == 32'd0);
                    ref_data_d  = (emitted_q == 32'd0) ? ref_buf[emit_idx] : '0;
                    if (emit_idx == LAST) begin
                        emitted_d = emitted_q + 32'd1;
                        if (emitted_q + 32'd1 == num_points_q) begin
                            state_d = FINISH;
                        end
                    end
                end
            end
            FINISH: begin
                state_d     = IDLE;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                fill_ptr_d  = 1'b0;
                fill_idx_d  = '0;
                full_d      = '0;
                drain_ptr_d = 1'b0;
                accepted_d  = '0;
                emitted_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partial query.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            num_points_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ref_idx_q    <= '0;
            fill_ptr_q   <= 1'b0;
            fill_idx_q   <= '0;
            full_q       <= '0;
            accepted_q   <= '0;
            drain_ptr_q  <= 1'b0;
            emitted_q    <= '0;
            out_valid_q  <= 1'b0;
            out_bank_q   <= 1'b0;
            out_idx_q    <= '0;
            load_ref_q   <= 1'b0;
            ref_data_q   <= '0;
            name_q       <= '0;
            value_q      <= '0;
        end else begin
            state_q      <= state_d;
            num_points_q <= num_points_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ref_idx_q    <= ref_idx_d;
            fill_ptr_q   <= fill_ptr_d;
            fill_idx_q   <= fill_idx_d;
            full_q       <= full_d;
            accepted_q   <= accepted_d;
            drain_ptr_q  <= drain_ptr_d;
            emitted_q    <= emitted_d;
            out_valid_q  <= out_valid_d;
            out_bank_q   <= out_bank_d;
            out_idx_q    <= out_idx_d;
            load_ref_q   <= load_ref_d;
            ref_data_q   <= ref_data_d;
            name_q       <= name_d;
            value_q      <= value_d;
        end
    end

    // Query and bank storage; contents are only meaningful behind the flags.
    always_ff @(posedge clk) begin
        if (ref_fire) begin
            ref_buf[ref_idx_q] <= bus.refIn;
        end
        if (pt_fire) begin
            bank_val[fill_ptr_q][fill_idx_q] <= bus.ptValueIn;
            if (fill_idx_q == '0) begin
                bank_name[fill_ptr_q] <= bus.ptNameIn;
            end
        end
    end

    assign bus.refReady     = ref_ready;
    assign bus.ptReady      = pt_ready;
    assign bus.outValid     = out_valid_q;
    assign bus.loadRef      = load_ref_q;
    assign bus.refDataOut   = ref_data_q;
    assign bus.dataNameOut  = name_q;
    assign bus.dataValueOut = value_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_knn_point_streamer.sv
// Testbench for knn_point_streamer with D=4: directed queries (continuous,
// toggling and random input), an empty query, a reset in the middle of a
// point, and random queries. Emitted words are matched against a queue of
// expected {loadRef, refDataOut, dataNameOut, dataValueOut} entries.
module tb_knn_point_streamer;
    localparam int D  = 4;
    localparam int W  = 32;
    localparam int EW = 1 + W + 32 + W;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  dbg_state;
    int unsigned cyc = 0;

    knn_point_streamer_if #(.dataWidth(W)) bus ();

    knn_point_streamer #(.dataWidth(W), .numberOfDimensions(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [EW-1:0] exp_q[$];
    int          checks = 0;
    int          passes = 0;
    bit          mon_en = 1'b0;
    int          words_seen = 0;
    int unsigned first_out_cyc = 0;
    int unsigned last_out_cyc = 0;
    int unsigned xfer_cyc = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Scoreboard: every emitted word must match the head of the queue, and
    // a point, once started, must continue on consecutive cycles.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.outValid) begin
                if (words_seen == 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                words_seen++;
                if (exp_q.size() == 0)
                    check("extra_word", 128'(exp_q.size()), 128'd1);
                else
                    check("word", 128'({bus.loadRef, bus.refDataOut, bus.dataNameOut, bus.dataValueOut}),
                          128'(exp_q.pop_front()));
            end else if (words_seen % D != 0) begin
                check("no_gap", 128'(bus.outValid), 128'd1);
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_outValid"}, 128'(bus.outValid), 128'd0);
        check({tag, "_loadRef"},  128'(bus.loadRef), 128'd0);
        check({tag, "_refData"},  128'(bus.refDataOut), 128'd0);
        check({tag, "_name"},     128'(bus.dataNameOut), 128'd0);
        check({tag, "_value"},    128'(bus.dataValueOut), 128'd0);
        check({tag, "_done"},     128'(bus.done), 128'd0);
        check({tag, "_busy"},     128'(bus.busy), 128'd0);
        check({tag, "_ptReady"},  128'(bus.ptReady), 128'd0);
        check({tag, "_refReady"}, 128'(bus.refReady), 128'd0);
        check({tag, "_state"},    128'(dbg_state), 128'd0);
    endtask

    // Driver tasks: entered and left on a negative edge.
    task automatic send_ref(input logic [W-1:0] val);
        int t = 0;
        bus.refValid = 1'b1;
        bus.refIn    = val;
        while (!bus.refReady && t < 200) begin @(negedge clk); t++; end
        if (!bus.refReady) check("ref_ready_timeout", 128'(bus.refReady), 128'd1);
        @(negedge clk);
        bus.refValid = 1'b0;
    endtask

    task automatic send_pt(input logic [31:0] name, input logic [W-1:0] val);
        int t = 0;
        bus.ptValid   = 1'b1;
        bus.ptNameIn  = name;
        bus.ptValueIn = val;
        while (!bus.ptReady && t < 200) begin @(negedge clk); t++; end
        if (!bus.ptReady) check("pt_ready_timeout", 128'(bus.ptReady), 128'd1);
        xfer_cyc = cyc;
        @(negedge clk);
        bus.ptValid = 1'b0;
    endtask

    // mode 0: continuous valid, 1: one idle cycle before each word (with a
    // stray start pulse in it), 2: random gaps and random data.
    task automatic gap(input int mode);
        if (mode == 1) begin
            bus.start     = 1'b1;
            bus.numPoints = 32'd9;
            @(negedge clk);
            bus.start = 1'b0;
        end else if (mode == 2) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic start_query(input int n, input int mode, output logic [W-1:0] rw [D]);
        for (int d = 0; d < D; d++) rw[d] = (mode == 2) ? W'($urandom) : W'(d + 1);
        words_seen    = 0;
        bus.start     = 1'b1;
        bus.numPoints = 32'(n);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.numPoints = 32'd77;
        check("busy_after_start", 128'(bus.busy), 128'd1);
        if (n > 0) begin
            for (int d = 0; d < D; d++) begin
                if (mode != 0) gap(mode);
                send_ref(rw[d]);
            end
            check("ref_ready_drop", 128'(bus.refReady), 128'd0);
        end
    endtask

    task automatic send_point(input int p, input int mode, input logic [W-1:0] rw [D]);
        logic [31:0]  nm;
        logic [W-1:0] v;
        logic         lr;
        logic [W-1:0] rd;
        nm = (mode == 2) ? $urandom : 32'(7 + p);
        for (int d = 0; d < D; d++) begin
            v  = (mode == 2) ? W'($urandom) : W'(5 + 4 * p + d);
            lr = (p == 0);
            rd = lr ? rw[d] : '0;
            exp_q.push_back({lr, rd, nm, v});
            if (mode != 0) gap(mode);
            send_pt(nm, v);
        end
    endtask

    task automatic run_query(input int n, input int mode);
        logic [W-1:0] rw [D];
        int unsigned  s_cyc;
        int unsigned  first_xfer = 0;
        int           t = 0;
        bit           ref_seen = 1'b0;
        s_cyc = cyc;
        start_query(n, mode, rw);
        for (int p = 0; p < n; p++) begin
            send_point(p, mode, rw);
            if (p == 0) first_xfer = xfer_cyc;
        end
        if (n > 0) begin
            // Extra word after the last point must be refused.
            bus.ptValid   = 1'b1;
            bus.ptValueIn = W'(32'hbad);
            check("excess_ready", 128'(bus.ptReady), 128'd0);
            @(negedge clk);
            bus.ptValid = 1'b0;
        end
        while (!bus.done && t < 1000) begin
            if (bus.refReady) ref_seen = 1'b1;
            @(negedge clk);
            t++;
        end
        check("done_seen", 128'(bus.done), 128'd1);
        check("busy_at_done", 128'(bus.busy), 128'd0);
        check("idle_at_done", 128'(dbg_state), 128'd0);
        check("queue_empty", 128'(exp_q.size()), 128'd0);
        if (n > 0) begin
            check("done_lat", 128'(cyc - last_out_cyc), 128'd1);
            check("start_lat", 128'(first_out_cyc - first_xfer), 128'd1);
            if (mode == 0) check("contig", 128'(last_out_cyc - first_out_cyc + 1), 128'(n * D));
        end else begin
            // One FINISH cycle after the start edge, then done.
            check("zero_done_lat", 128'(cyc - s_cyc), 128'd2);
            check("zero_no_ref", 128'(ref_seen), 128'd0);
        end
        @(negedge clk);
        check("done_pulse", 128'(bus.done), 128'd0);
    endtask

    task automatic reset_mid_point();
        logic [W-1:0] rw [D];
        int           t = 0;
        start_query(2, 0, rw);
        send_point(0, 0, rw);
        while (words_seen < 2 && t < 100) begin @(negedge clk); #1; t++; end
        check("reset_reached", 128'(words_seen), 128'd2);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        check_quiet("mid_reset");
        reset = 1'b0;
        exp_q.delete();
        words_seen = 0;
        mon_en = 1'b1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.numPoints = '0;
        bus.refIn     = '0;
        bus.refValid  = 1'b0;
        bus.ptNameIn  = '0;
        bus.ptValueIn = '0;
        bus.ptValid   = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        run_query(1, 0);
        run_query(3, 0);
        run_query(2, 1);
        run_query(4, 0);
        run_query(0, 0);
        reset_mid_point();
        run_query(1, 2);
        for (int i = 0; i < 4; i++) run_query($urandom_range(1, 5), 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/knn_point_streamer.md
Name: knn_point_streamer

Overview:
- Upstream feeder for the kNN distance/sort datapath (distanceCalculationAccumulator + kSorting).
- Accepts one query (reference) point and then a stream of named training points from a bursty valid/ready source.
- Buffers each training point completely, then emits it as numberOfDimensions back-to-back words, so the per-dimension accumulator never sees a mid-point bubble.
- Drives loadRef/refData alignment for the first point and pulses done after the last word.

Parameters:
- dataWidth, 32, width of one dimension value.
- numberOfDimensions, 32, words per point (D); legal range 2..1024.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse; begins a query.
- numPoints  input  32  training points in this query, sampled on start.
- refIn  input  dataWidth  query point word.
- refValid  input  1  refIn valid.
- refReady  output  1  streamer accepts refIn.
- ptNameIn  input  32  training point name, meaningful on dimension-0 word.
- ptValueIn  input  dataWidth  training point word.
- ptValid  input  1  ptValueIn valid.
- ptReady  output  1  streamer accepts ptValueIn.
- outValid  output  1  output word valid; downstream advances only when high.
- loadRef  output  1  high for all D words of the first emitted point.
- refDataOut  output  dataWidth  query word i while loadRef, else 0.
- dataNameOut  output  32  name of point being emitted, constant across its D words.
- dataValueOut  output  dataWidth  dimension word of point being emitted.
- done  output  1  one-cycle pulse, end of query.
- busy  output  1  high from start until done.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: all outputs 0; state IDLE; bank, word and point counters cleared. Reset mid-query discards partial points and the query point; no done pulse.
- States: IDLE, REF_FILL, RUN, FINISH.
- IDLE: start -> latch numPoints, busy=1. numPoints==0 -> FINISH; else REF_FILL. start while busy is ignored.
- REF_FILL: refReady=1; each refValid&&refReady writes refBuf[i], i=0..D-1. After word D-1 -> RUN, refReady=0 next cycle.
- RUN input side: two banks (ping-pong), each D values + name. Transfer = ptValid&&ptReady. Name captured on the dimension-0 transfer only. ptReady=1 when the fill bank is not full and pointsAccepted<numPoints. Bank marked full on its D-1 transfer; fill pointer toggles. ptReady=0 while both banks are full.
- RUN output side: when idle and a bank is full, emission begins the next cycle (registered outputs). The bank's D words are emitted on D consecutive cycles with outValid=1 and word index 0..D-1. The bank is freed on the cycle its last word is emitted; the input side may refill it the following cycle. Banks are emitted in fill order. Next full bank starts the cycle immediately after the previous point's last word: zero-gap between points when data is available. Gaps occur only between points, never within one.
- loadRef/refDataOut: asserted only during the first point of a query; refDataOut=refBuf[idx] aligned word-for-word with dataValueOut.
- FINISH entry: pointsEmitted==numPoints after the last word. done=1 for exactly one cycle, the cycle after the last outValid. busy=0 and IDLE in the same cycle as done.
- Simultaneous fill-complete and drain-complete on different banks in one cycle: both take effect, no lost point.
- Excess ptValid after numPoints accepted: not accepted (ptReady=0).
- Counters: word index width clog2(D); point counters 32-bit, no wrap within a query.

Test Plan:
- D=4, numPoints=1, ref {1,2,3,4}, point name 7 {5,6,7,8}, all valid continuous -> outValid on 4 consecutive cycles, dataValueOut 5,6,7,8, refDataOut 1,2,3,4, loadRef=1, dataName=7 throughout, done one cycle after the 4th word.
- D=4, numPoints=3, ptValid continuous -> 12 contiguous outValid cycles, loadRef only on first 4, names on dimension-0 words carried for each point.
- D=4, numPoints=2, ptValid toggling 1/0 -> each point's 4 words emitted back-to-back with no intra-point gap; outputs begin one cycle after the 4th transfer of a point.
- Backpressure: D=4, numPoints=4, continuous input while output is busy -> ptReady drops when both banks are full and recovers the cycle after a bank frees; no word lost or duplicated.
- numPoints=0 -> REF_FILL skipped, refReady never high, done pulses one cycle after start.
- Reset asserted mid-RUN after 2 words of point 1 -> all outputs 0 next cycle. A new start with fresh data emits only the new point.
